// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader for the instruction RAM: MAGIC, COUNT, LE words, XOR checksum.
module prog_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int REM_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CSUM} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    take;
  logic [IDX_W-1:0]        idx;
  logic [REM_W-1:0]        remaining;
  logic [7:0]              checksum;
  logic [DATA_WIDTH-1:0]   word_buf;
  logic [DATA_WIDTH-1:0]   word_nxt;

  assign take = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take && rx_data == MAGIC) state_nxt = S_COUNT;
      S_COUNT: if (take) state_nxt = S_DATA;
      S_DATA:  if (take && idx == LAST_IDX) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (remaining == REM_W'(1)) ? S_CSUM : S_DATA;
      S_CSUM:  if (take) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pure state decodes: rx_ready must not depend on rx_valid.
  always_comb begin
    rx_ready = (state != S_WRITE);
    mem_we   = (state == S_WRITE);
    busy     = (state != S_IDLE);
  end

  always_comb begin
    word_nxt = word_buf;
    word_nxt[{idx, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx        <= '0;
      remaining  <= '0;
      checksum   <= '0;
      word_buf   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take && rx_data == MAGIC) begin
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            checksum   <= '0;
          end
        end
        S_COUNT: begin
          if (take) begin
            // A count of zero means a full memory image.
            remaining <= (rx_data == 8'd0) ? (REM_W'(1) << ADDR_WIDTH) : REM_W'(rx_data);
            mem_addr  <= '0;
            idx       <= '0;
          end
        end
        S_DATA: begin
          if (take) begin
            checksum <= checksum ^ rx_data;
            word_buf <= word_nxt;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              mem_wdata <= word_nxt;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        S_CSUM: begin
          if (take) begin
            if (rx_data == checksum) begin
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
